// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES-128 round sequencer:
// controller state encoding, round count, rcon constants and the
// GF(2^8) doubling used to step the round constant.
package aes_pkg;

    localparam int          AES_NR        = 10;
    localparam logic [7:0]  RCON_INIT     = 8'h01;
    localparam logic [7:0]  AES_RCON_POLY = 8'h1B;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_ARK0 = 3'd2,
        ST_SB   = 3'd3,
        ST_SR   = 3'd4,
        ST_MC   = 3'd5,
        ST_ARK  = 3'd6,
        ST_DONE = 3'd7
    } aes_state_e;

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_RCON_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Host/datapath handshake and stage-enable bundle of the AES round
// sequencer. The master side is the host wrapper that requests work and
// consumes results; the slave side is the sequencer itself.
interface aes_round_ctrl_if;

    logic       pi_start;
    logic       pi_abort;
    logic       pi_out_ready;
    logic       po_busy;
    logic       po_done;
    logic       po_load_en;
    logic       po_sb_en;
    logic       po_sr_en;
    logic       po_mc_en;
    logic       po_ark_en;
    logic       po_ark_sel;
    logic       po_ke_en;
    logic [3:0] po_round;
    logic [7:0] po_rcon;

    modport master (
        output pi_start, pi_abort, pi_out_ready,
        input  po_busy, po_done, po_load_en, po_sb_en, po_sr_en, po_mc_en,
               po_ark_en, po_ark_sel, po_ke_en, po_round, po_rcon
    );

    modport slave (
        input  pi_start, pi_abort, pi_out_ready,
        output po_busy, po_done, po_load_en, po_sb_en, po_sr_en, po_mc_en,
               po_ark_en, po_ark_sel, po_ke_en, po_round, po_rcon
    );

endinterface

// File: rtl/aes_rcon_gen.sv
// Round-constant register: reloads to the initial value on load and
// steps by xtime on advance. Load wins if both are asserted.
module aes_rcon_gen
    import aes_pkg::*;
#(
    parameter logic [7:0] INIT = 8'h01
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       advance,
    output logic [7:0] rcon
);

    logic [7:0] rcon_r;

    // Round constant register with reload and advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcon_r <= INIT;
        end else if (load) begin
            rcon_r <= INIT;
        end else if (advance) begin
            rcon_r <= xtime(rcon_r);
        end else begin
            rcon_r <= rcon_r;
        end
    end

    assign rcon = rcon_r;

endmodule

// File: rtl/aes_round_ctrl.sv
// Sequencer for the iterative AES-128 datapath. Walks
// LOAD -> ARK0 -> {SB, SR, MC, ARK} x NR (no MC in the last round) -> DONE,
// issuing one stage enable per cycle. All outputs are decoded from the
// registered state, round and rcon only, so no input reaches an output
// combinationally.
module aes_round_ctrl #(
    parameter int         NR        = aes_pkg::AES_NR,
    parameter logic [7:0] RCON_INIT = aes_pkg::RCON_INIT
) (
    input  logic            pi_clk,
    input  logic            pi_rst_n,
    aes_round_ctrl_if.slave bus
);

    import aes_pkg::*;

    localparam logic [3:0] NR_R = 4'(NR);

    aes_state_e state_r;
    aes_state_e state_nx_s;
    logic [3:0] round_r;
    logic [3:0] round_nx_s;
    logic       rcon_load_s;
    logic       rcon_adv_s;
    logic [7:0] rcon_s;

    aes_rcon_gen #(
        .INIT (RCON_INIT)
    ) u_rcon (
        .clk     (pi_clk),
        .rst_n   (pi_rst_n),
        .load    (rcon_load_s),
        .advance (rcon_adv_s),
        .rcon    (rcon_s)
    );

    // State and round-counter registers.
    always_ff @(posedge pi_clk or negedge pi_rst_n) begin
        if (!pi_rst_n) begin
            state_r <= ST_IDLE;
            round_r <= 4'd0;
        end else begin
            state_r <= state_nx_s;
            round_r <= round_nx_s;
        end
    end

    // Next-state, round and rcon control; abort overrides everything.
    always_comb begin
        state_nx_s  = state_r;
        round_nx_s  = round_r;
        rcon_load_s = 1'b0;
        rcon_adv_s  = 1'b0;
        if (bus.pi_abort && (state_r != ST_IDLE)) begin
            state_nx_s  = ST_IDLE;
            round_nx_s  = 4'd0;
            rcon_load_s = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    round_nx_s = 4'd0;
                    if (bus.pi_start) begin
                        state_nx_s = ST_LOAD;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    state_nx_s = ST_ARK0;
                end
                ST_ARK0: begin
                    state_nx_s = ST_SB;
                    round_nx_s = 4'd1;
                end
                ST_SB: begin
                    state_nx_s = ST_SR;
                end
                ST_SR: begin
                    if (round_r < NR_R) begin
                        state_nx_s = ST_MC;
                    end else begin
                        state_nx_s = ST_ARK;
                    end
                end
                ST_MC: begin
                    state_nx_s = ST_ARK;
                end
                ST_ARK: begin
                    if (round_r < NR_R) begin
                        state_nx_s = ST_SB;
                        round_nx_s = round_r + 4'd1;
                        rcon_adv_s = 1'b1;
                    end else begin
                        state_nx_s = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.pi_out_ready) begin
                        // Accept and restart in the same cycle when asked.
                        state_nx_s  = bus.pi_start ? ST_LOAD : ST_IDLE;
                        round_nx_s  = 4'd0;
                        rcon_load_s = 1'b1;
                    end else begin
                        state_nx_s = ST_DONE;
                    end
                end
                default: begin
                    state_nx_s  = ST_IDLE;
                    round_nx_s  = 4'd0;
                    rcon_load_s = 1'b1;
                end
            endcase
        end
    end

    // Output decode from registered state only.
    always_comb begin
        bus.po_busy    = 1'b0;
        bus.po_done    = 1'b0;
        bus.po_load_en = 1'b0;
        bus.po_sb_en   = 1'b0;
        bus.po_sr_en   = 1'b0;
        bus.po_mc_en   = 1'b0;
        bus.po_ark_en  = 1'b0;
        bus.po_ark_sel = 1'b0;
        bus.po_ke_en   = 1'b0;
        bus.po_round   = round_r;
        bus.po_rcon    = rcon_s;
        case (state_r)
            ST_IDLE: begin
                bus.po_busy = 1'b0;
            end
            ST_LOAD: begin
                bus.po_busy    = 1'b1;
                bus.po_load_en = 1'b1;
            end
            ST_ARK0: begin
                bus.po_busy   = 1'b1;
                bus.po_ark_en = 1'b1;
            end
            ST_SB: begin
                bus.po_busy  = 1'b1;
                bus.po_sb_en = 1'b1;
                bus.po_ke_en = 1'b1;
            end
            ST_SR: begin
                bus.po_busy  = 1'b1;
                bus.po_sr_en = 1'b1;
            end
            ST_MC: begin
                bus.po_busy  = 1'b1;
                bus.po_mc_en = 1'b1;
            end
            ST_ARK: begin
                bus.po_busy    = 1'b1;
                bus.po_ark_en  = 1'b1;
                bus.po_ark_sel = (round_r < NR_R);
            end
            ST_DONE: begin
                bus.po_done = 1'b1;
            end
            default: begin
                bus.po_busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl. A small AES-128 datapath model is
// clocked by the sequencer's enables so the FIPS-197 vector can be
// checked end to end.
module tb_aes_round_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_round_ctrl_if bus();

    aes_round_ctrl dut (
        .pi_clk   (clk),
        .pi_rst_n (rst_n),
        .bus      (bus)
    );

    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    int checks = 0;
    int errors = 0;

    logic [127:0] st_m  = 128'h0;
    logic [127:0] sb_m  = 128'h0;
    logic [127:0] sr_m  = 128'h0;
    logic [127:0] mc_m  = 128'h0;
    logic [127:0] key_m = 128'h0;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic hi;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            hi = aa[7];
            aa = {aa[6:0], 1'b0};
            if (hi) aa = aa ^ 8'h1b;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        if (x != 8'h00) begin
            for (int i = 1; i < 256; i++) begin
                if (gmul(x, 8'(i)) == 8'h01) inv = 8'(i);
            end
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] v);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(v[127-8*i -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] v);
        logic [127:0] o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127-8*(r+4*c) -: 8] = v[127-8*(r+4*((c+r)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] v);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = v[127-8*(4*c)   -: 8];
            a1 = v[127-8*(4*c+1) -: 8];
            a2 = v[127-8*(4*c+2) -: 8];
            a3 = v[127-8*(4*c+3) -: 8];
            o[127-8*(4*c)   -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
            o[127-8*(4*c+1) -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
            o[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
            o[127-8*(4*c+3) -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
        return o;
    endfunction

    function automatic logic [127:0] key_exp(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, rot, t;
        w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
        rot = {w3[23:0], w3[31:24]};
        t = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
        t = t ^ {rc, 24'h000000};
        w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Datapath model driven by the sequencer's enables.
    always @(posedge clk) begin
        if (bus.po_load_en) begin
            sr_m  <= PT;
            key_m <= KEY;
        end
        if (bus.po_sb_en) sb_m <= sub_bytes(st_m);
        if (bus.po_ke_en) key_m <= key_exp(key_m, bus.po_rcon);
        if (bus.po_sr_en) sr_m <= shift_rows(sb_m);
        if (bus.po_mc_en) mc_m <= mix_columns(sr_m);
        if (bus.po_ark_en) st_m <= (bus.po_ark_sel ? mc_m : sr_m) ^ key_m;
    end

    function automatic logic [6:0] enables();
        return {bus.po_load_en, bus.po_sb_en, bus.po_sr_en, bus.po_mc_en,
                bus.po_ark_en, bus.po_ark_sel, bus.po_ke_en};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (bus.po_done !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        checks++;
        if (bus.po_done !== 1'b1) begin
            errors++;
            $display("FAIL wait_done: po_done=%b after %0d cycles, required 1", bus.po_done, n);
        end
    endtask

    task automatic test_reset();
        bus.pi_start = 1'b0; bus.pi_abort = 1'b0; bus.pi_out_ready = 1'b0;
        rst_n = 1'b0;
        #12;
        checks++;
        if ({bus.po_busy, bus.po_done, enables()} !== 9'h000) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 0", {bus.po_busy, bus.po_done, enables()});
        end
        checks++;
        if (bus.po_round !== 4'd0 || bus.po_rcon !== 8'h01) begin
            errors++;
            $display("FAIL reset_round_rcon: got %0d/%h required 0/01", bus.po_round, bus.po_rcon);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_latency_counts();
        int n_sb = 0, n_sr = 0, n_mc = 0, n_ark = 0;
        logic [7:0] rcon_log [10];
        logic [7:0] exp_rcon [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                      8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
        bus.pi_out_ready = 1'b1;
        bus.pi_start = 1'b1;
        tick();
        bus.pi_start = 1'b0;
        for (int cyc = 1; cyc <= 41; cyc++) begin
            if (cyc == 1) begin
                checks++;
                if (bus.po_load_en !== 1'b1) begin
                    errors++;
                    $display("FAIL load_cycle1: load_en=%b required 1", bus.po_load_en);
                end
            end
            if (cyc == 2) begin
                checks++;
                if (bus.po_ark_en !== 1'b1 || bus.po_ark_sel !== 1'b0 || bus.po_round !== 4'd0) begin
                    errors++;
                    $display("FAIL ark0_cycle2: ark_en=%b sel=%b round=%0d required 1/0/0",
                             bus.po_ark_en, bus.po_ark_sel, bus.po_round);
                end
            end
            checks++;
            if (bus.po_busy !== 1'b1 || bus.po_done !== 1'b0 ||
                (32'(bus.po_load_en) + 32'(bus.po_sb_en) + 32'(bus.po_sr_en) +
                 32'(bus.po_mc_en) + 32'(bus.po_ark_en)) != 1 ||
                (bus.po_ke_en === 1'b1 && bus.po_sb_en !== 1'b1)) begin
                errors++;
                $display("FAIL onehot_c%0d: busy=%b done=%b en=%b required busy, one enable",
                         cyc, bus.po_busy, bus.po_done, enables());
            end
            if (bus.po_sb_en === 1'b1 && n_sb < 10) begin
                checks++;
                if (bus.po_round !== 4'(n_sb + 1) || cyc != 3 + 4 * n_sb) begin
                    errors++;
                    $display("FAIL sb_round: cycle %0d round %0d required cycle %0d round %0d",
                             cyc, bus.po_round, 3 + 4 * n_sb, n_sb + 1);
                end
                rcon_log[n_sb] = bus.po_rcon;
            end
            n_sb  += 32'(bus.po_sb_en);
            n_sr  += 32'(bus.po_sr_en);
            n_mc  += 32'(bus.po_mc_en);
            n_ark += 32'(bus.po_ark_en);
            tick();
        end
        checks++;
        if (bus.po_done !== 1'b1 || bus.po_busy !== 1'b0 || bus.po_round !== 4'd10 || enables() !== 7'h00) begin
            errors++;
            $display("FAIL done_cycle42: done=%b busy=%b round=%0d en=%b required 1/0/10/0",
                     bus.po_done, bus.po_busy, bus.po_round, enables());
        end
        checks++;
        if (n_sb != 10 || n_sr != 10 || n_mc != 9 || n_ark != 11) begin
            errors++;
            $display("FAIL pulse_counts: sb=%0d sr=%0d mc=%0d ark=%0d required 10/10/9/11",
                     n_sb, n_sr, n_mc, n_ark);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (i >= n_sb || rcon_log[i] !== exp_rcon[i]) begin
                errors++;
                $display("FAIL rcon_%0d: got %h required %h", i + 1, rcon_log[i], exp_rcon[i]);
            end
        end
        checks++;
        if (st_m !== CT) begin
            errors++;
            $display("FAIL ciphertext_first: got %h required %h", st_m, CT);
        end
        tick();
        checks++;
        if (bus.po_done !== 1'b0 || bus.po_round !== 4'd0 || bus.po_rcon !== 8'h01) begin
            errors++;
            $display("FAIL done_one_cycle: done=%b round=%0d rcon=%h required 0/0/01",
                     bus.po_done, bus.po_round, bus.po_rcon);
        end
    endtask

    task automatic test_back_to_back();
        bus.pi_out_ready = 1'b0;
        bus.pi_start = 1'b1;
        tick();
        bus.pi_start = 1'b0;
        wait_done(60);
        for (int i = 0; i < 4; i++) begin
            bus.pi_start = (i == 1);
            tick();
            bus.pi_start = 1'b0;
            checks++;
            if (bus.po_done !== 1'b1 || bus.po_busy !== 1'b0 || enables() !== 7'h00) begin
                errors++;
                $display("FAIL hold_done_%0d: done=%b busy=%b en=%b required 1/0/0",
                         i, bus.po_done, bus.po_busy, enables());
            end
        end
        bus.pi_out_ready = 1'b1;
        bus.pi_start = 1'b1;
        tick();
        bus.pi_start = 1'b0;
        checks++;
        if (bus.po_load_en !== 1'b1 || bus.po_done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_load: load_en=%b done=%b required 1/0", bus.po_load_en, bus.po_done);
        end
        wait_done(60);
        checks++;
        if (st_m !== CT) begin
            errors++;
            $display("FAIL ciphertext_b2b: got %h required %h", st_m, CT);
        end
        tick();
    endtask

    task automatic test_abort();
        int seen_done = 0;
        bus.pi_out_ready = 1'b1;
        bus.pi_start = 1'b1;
        tick();
        bus.pi_start = 1'b0;
        for (int i = 1; i < 20; i++) tick();
        checks++;
        if (bus.po_sr_en !== 1'b1 || bus.po_round !== 4'd5 || bus.po_rcon !== 8'h10) begin
            errors++;
            $display("FAIL abort_pre: sr_en=%b round=%0d rcon=%h required 1/5/10",
                     bus.po_sr_en, bus.po_round, bus.po_rcon);
        end
        bus.pi_abort = 1'b1;
        tick();
        bus.pi_abort = 1'b0;
        checks++;
        if ({bus.po_busy, bus.po_done, enables()} !== 9'h000 ||
            bus.po_round !== 4'd0 || bus.po_rcon !== 8'h01) begin
            errors++;
            $display("FAIL abort_idle: out=%b round=%0d rcon=%h required 0/0/01",
                     {bus.po_busy, bus.po_done, enables()}, bus.po_round, bus.po_rcon);
        end
        for (int i = 0; i < 30; i++) begin
            seen_done += 32'(bus.po_done);
            tick();
        end
        checks++;
        if (seen_done != 0) begin
            errors++;
            $display("FAIL abort_no_done: done cycles %0d required 0", seen_done);
        end
        bus.pi_start = 1'b1;
        tick();
        bus.pi_start = 1'b0;
        wait_done(60);
        checks++;
        if (st_m !== CT) begin
            errors++;
            $display("FAIL ciphertext_after_abort: got %h required %h", st_m, CT);
        end
        tick();
    endtask

    task automatic test_async_reset();
        bus.pi_out_ready = 1'b1;
        bus.pi_start = 1'b1;
        tick();
        bus.pi_start = 1'b0;
        for (int i = 1; i < 21; i++) tick();
        checks++;
        if (bus.po_mc_en !== 1'b1 || bus.po_rcon !== 8'h10) begin
            errors++;
            $display("FAIL pre_reset: mc_en=%b rcon=%h required 1/10", bus.po_mc_en, bus.po_rcon);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.po_busy, bus.po_done, enables()} !== 9'h000 ||
            bus.po_round !== 4'd0 || bus.po_rcon !== 8'h01) begin
            errors++;
            $display("FAIL async_reset: out=%b round=%0d rcon=%h required 0/0/01",
                     {bus.po_busy, bus.po_done, enables()}, bus.po_round, bus.po_rcon);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.po_busy !== 1'b0 || bus.po_rcon !== 8'h01) begin
            errors++;
            $display("FAIL post_reset_idle: busy=%b rcon=%h required 0/01", bus.po_busy, bus.po_rcon);
        end
    endtask

    // Test sequence.
    initial begin
        test_reset();
        test_latency_counts();
        test_back_to_back();
        test_abort();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Sequencer for the iterative AES-128 encryption datapath: sub_bytes, shift_rows, mix_columns and add_round_key stage registers plus the key-expansion register.
- Each stage is a registered, enable-gated 128-bit stage. This block issues exactly one stage enable per cycle and tracks the round number and round constant (rcon).
- Provides a start/done handshake to the host-side wrapper.

Parameters:
- NR, 10, number of rounds; the final round omits mix_columns.
- RCON_INIT, 8'h01, rcon value issued for round 1.

Ports:
- pi_clk  in  1  clock; all state updates on the rising edge.
- pi_rst_n  in  1  asynchronous, active-low reset.
- pi_start  in  1  request to encrypt the block and key currently on the datapath inputs.
- pi_abort  in  1  synchronous abort of the current operation.
- pi_out_ready  in  1  consumer accepts the result while po_done=1.
- po_busy  out  1  high from LOAD through the last ARK.
- po_done  out  1  result valid in the state register; held until accepted.
- po_load_en  out  1  load plaintext into the state register and cipher key into the key register.
- po_sb_en  out  1  sub_bytes stage enable.
- po_sr_en  out  1  shift_rows stage enable.
- po_mc_en  out  1  mix_columns stage enable.
- po_ark_en  out  1  add_round_key stage enable.
- po_ark_sel  out  1  ARK data source: 0 = shift_rows output (round 0 load path and final round), 1 = mix_columns output.
- po_ke_en  out  1  key-expansion register enable.
- po_round  out  4  current round index, 0..NR.
- po_rcon  out  8  round constant for the key expansion in progress.

Behaviour:
- Reset (pi_rst_n=0, asynchronous): state=IDLE; all outputs 0 except po_rcon=RCON_INIT.
- States: IDLE, LOAD, ARK0, SB, SR, MC, ARK, DONE.
- IDLE:
  - pi_start=1 -> LOAD.
  - po_round=0, po_rcon=RCON_INIT.
- LOAD (1 cycle): po_load_en=1 -> ARK0.
- ARK0 (1 cycle): po_ark_en=1, po_ark_sel=0, po_round=0 -> SB with round=1.
- SB: po_sb_en=1, po_ke_en=1 using the current po_rcon. The key register holds round key r by the ARK cycle -> SR.
- SR: po_sr_en=1.
  - round<NR -> MC.
  - round=NR -> ARK.
- MC: po_mc_en=1 -> ARK.
- ARK: po_ark_en=1, po_ark_sel=(round<NR).
  - round<NR -> SB; round increments; rcon updates to xtime(rcon).
  - round=NR -> DONE.
- rcon update rule: xtime = {rcon[6:0],1'b0} XOR (rcon[7] ? 8'h1B : 8'h00). Sequence is 01,02,04,08,10,20,40,80,1B,36.
- DONE: po_done=1, po_busy=0, po_round=NR.
  - pi_out_ready=1 -> IDLE; round resets to 0, rcon to RCON_INIT.
  - pi_out_ready=1 and pi_start=1 in the same cycle -> LOAD directly (back-to-back, no idle bubble).
- Latency: start sampled at cycle 0; LOAD at 1; ARK0 at 2; round r SB at 3+4(r-1); round NR: SB 39, SR 40, ARK 41; po_done=1 from cycle 42.
- pi_start while busy or while done without pi_out_ready: ignored, not queued.
- pi_abort=1 in any non-IDLE state: next state IDLE, all enables 0 in the following cycle, round and rcon reinitialised, po_done never asserted. Abort has priority over start.
- Enables are one-hot; at most one of sb/sr/mc/ark/load is high in any cycle. po_ke_en may coincide only with po_sb_en.
- All outputs are registered or decoded from registered state only, with no combinational path from inputs to outputs.

Decomposition:
- aes_pkg holds:
  - state enum;
  - AES_NR=10;
  - RCON_INIT;
  - AES_RCON_POLY=8'h1B;
  - xtime function.
- One natural sub-module, aes_rcon_gen: rcon register with load/advance inputs. Used here and reusable by a future key-schedule block.

Test Plan:
- Reset then pulse pi_start with pi_out_ready=1 -> po_load_en at cycle 1, po_ark_en at 2, po_done at 42 for exactly 1 cycle; exactly 10 SB, 10 SR, 9 MC and 11 ARK pulses counted.
- Log po_rcon at each po_ke_en -> 01,02,04,08,10,20,40,80,1B,36; po_round reads 1..10 at the matching SB cycles.
- Full datapath with FIPS-197 key 000102..0F, plaintext 00112233..FF -> ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a.
- Hold pi_out_ready=0 -> po_done stays 1 and all enables stay 0; pulse pi_start meanwhile -> ignored; assert ready+start together -> LOAD next cycle.
- pi_abort at cycle 20 -> IDLE at 21, no po_done; a subsequent start produces the correct FIPS-197 ciphertext.
- Deassert pi_rst_n asynchronously mid-round 5 -> outputs clear without a clock edge; po_rcon=01 after reset.
